mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_wait_ctr.sv | 42 ++++
 rtl/mem_stage_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
// Holds the FSM state encoding, the default timeout and the read value returned on timeout.
package mem_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam logic [31:0] TIMEOUT_RDATA   = 32'h0;

endpackage : mem_pkg

// File: rtl/mem_wait_ctr.sv
// Saturating wait counter for outstanding data-memory accesses.
// expired flags the last cycle an access may wait before it is abandoned.
module mem_wait_ctr
  import mem_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         enable,
  output logic [$clog2(LIMIT+1)-1:0]   count,
  output logic                         expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != W'(LIMIT))) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: clocked state is written with non-blocking assignments only, so every
  // flop samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == W'(LIMIT - 1));

endmodule : mem_wait_ctr

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns load/store flags into a req/ready handshake with data
// memory, stalls the pipeline while the access is outstanding and times out a silent memory.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stallM,
  output logic [31:0] ReadDataM,
  output logic        ReadValidM,
  output logic        mem_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic        stall;

  logic          ctr_clear;
  logic          ctr_enable;
  logic          ctr_expired;
  logic [CW-1:0] ctr_count_unused;

  logic access;
  assign access = MemWriteM | MemtoRegM;

  mem_wait_ctr #(
    .LIMIT (TIMEOUT)
  ) u_wait_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .count   (ctr_count_unused),
    .expired (ctr_expired)
  );

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    err_d      = err_q;
    ctr_clear  = 1'b0;
    ctr_enable = 1'b0;
    stall      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          stall     = 1'b1;
          addr_d    = ALUOutM;
          wdata_d   = WriteDataM;
          we_d      = MemWriteM;
          ctr_clear = 1'b1;
          state_d   = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
          if (!we_q) begin
            rdata_d  = mem_rdata;
            rvalid_d = 1'b1;
          end
        end else begin
          ctr_enable = 1'b1;
          if (ctr_expired) begin
            // Abandon the access but release the pipeline, as if memory had answered.
            state_d = ST_IDLE;
            err_d   = 1'b1;
            if (!we_q) begin
              rdata_d  = TIMEOUT_RDATA;
              rvalid_d = 1'b1;
            end
          end else begin
            stall = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    req_d = (state_d == ST_ACCESS);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // The idle decode would stall on a pending access even while reset is held.
  assign stallM     = reset_n & stall;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign ReadDataM  = rdata_q;
  assign ReadValidM = rvalid_q;
  assign mem_err    = err_q;

endmodule : mem_stage_ctrl

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with TIMEOUT=4; load results are checked
// against a queue of expected ReadDataM values filled as each load is issued.
module tb_mem_stage_ctrl;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        MemWriteM, MemtoRegM;
  logic [31:0] ALUOutM, WriteDataM;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, stallM, ReadValidM, mem_err;
  logic [31:0] mem_addr, mem_wdata, ReadDataM;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  always #5 clock = ~clock;

  mem_stage_ctrl #(
    .TIMEOUT (TO)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .MemWriteM  (MemWriteM),
    .MemtoRegM  (MemtoRegM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stallM     (stallM),
    .ReadDataM  (ReadDataM),
    .ReadValidM (ReadValidM),
    .mem_err    (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Every ReadValidM pulse must match the oldest outstanding load.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && ReadValidM === 1'b1) begin
      if (sb.size() == 0) check("unexpected_rvalid", 32'(ReadValidM), 32'h0);
      else                check("sb_rdata", ReadDataM, sb.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    MemWriteM  = 1'b1;
    MemtoRegM  = 1'b0;
    ALUOutM    = 32'h0000_0001;
    WriteDataM = 32'hFFFF_FFFF;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    #2;
    check("rst_mem_req",    32'(mem_req), 32'h0);
    check("rst_mem_we",     32'(mem_we), 32'h0);
    check("rst_mem_addr",   mem_addr, 32'h0);
    check("rst_mem_wdata",  mem_wdata, 32'h0);
    check("rst_rdata",      ReadDataM, 32'h0);
    check("rst_rvalid",     32'(ReadValidM), 32'h0);
    check("rst_mem_err",    32'(mem_err), 32'h0);
    check("rst_stall",      32'(stallM), 32'h0);
    tick(); tick();
    reset_n   = 1'b1;
    MemWriteM = 1'b0;
    #1 check("idle_stall", 32'(stallM), 32'h0);

    // Load, acked on the first ACCESS cycle.
    tick();
    MemtoRegM = 1'b1; ALUOutM = 32'h10; sb.push_back(32'hCAFE_F00D);
    #1 check("ld_detect_stall", 32'(stallM), 32'h1);
    check("ld_detect_req", 32'(mem_req), 32'h0);
    tick();
    ALUOutM = 32'hFFFF_0000; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1 check("ld_req", 32'(mem_req), 32'h1);
    check("ld_we",   32'(mem_we), 32'h0);
    check("ld_addr", mem_addr, 32'h10);
    check("ld_ack_stall", 32'(stallM), 32'h0);
    tick();
    MemtoRegM = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    #1 check("ld_req_drop", 32'(mem_req), 32'h0);
    check("ld_rvalid", 32'(ReadValidM), 32'h1);
    check("ld_rdata",  ReadDataM, 32'hCAFE_F00D);
    tick();
    check("ld_rvalid_pulse", 32'(ReadValidM), 32'h0);
    check("ld_rdata_hold", ReadDataM, 32'hCAFE_F00D);

    // Store, three wait cycles then acked on the fourth ACCESS cycle.
    MemWriteM = 1'b1; ALUOutM = 32'h20; WriteDataM = 32'h1234_5678;
    #1 check("st_detect_stall", 32'(stallM), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      ALUOutM = 32'hDEAD_0000 + 32'(i); WriteDataM = ~WriteDataM;
      #1 check("st_wait_req",   32'(mem_req), 32'h1);
      check("st_wait_we",    32'(mem_we), 32'h1);
      check("st_wait_addr",  mem_addr, 32'h20);
      check("st_wait_wdata", mem_wdata, 32'h1234_5678);
      check("st_wait_stall", 32'(stallM), 32'h1);
    end
    tick();
    mem_ready = 1'b1;
    #1 check("st_ack_req",   32'(mem_req), 32'h1);
    check("st_ack_stall", 32'(stallM), 32'h0);
    tick();
    MemWriteM = 1'b0; mem_ready = 1'b0;
    #1 check("st_req_drop", 32'(mem_req), 32'h0);
    check("st_no_rvalid", 32'(ReadValidM), 32'h0);
    check("st_no_err",    32'(mem_err), 32'h0);

    // Load that is never acked: abandoned after TO ACCESS cycles.
    MemtoRegM = 1'b1; ALUOutM = 32'h30; mem_rdata = 32'hDEAD_BEEF;
    sb.push_back(32'h0);
    #1 check("to_detect_stall", 32'(stallM), 32'h1);
    for (int k = 0; k < int'(TO); k++) begin
      tick();
      check("to_req",   32'(mem_req), 32'h1);
      check("to_stall", 32'(stallM), (k == int'(TO) - 1) ? 32'h0 : 32'h1);
      check("to_err_pending", 32'(mem_err), 32'h0);
    end
    tick();
    MemtoRegM = 1'b0;
    #1 check("to_req_drop", 32'(mem_req), 32'h0);
    check("to_err",    32'(mem_err), 32'h1);
    check("to_rvalid", 32'(ReadValidM), 32'h1);
    check("to_rdata",  ReadDataM, 32'h0);

    // Back-to-back load then store with mem_ready held high, also in IDLE.
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222; MemtoRegM = 1'b1; ALUOutM = 32'h40;
    sb.push_back(32'h1111_2222);
    #1 check("b2b_ld_stall", 32'(stallM), 32'h1);
    tick();
    check("b2b_ld_req",  32'(mem_req), 32'h1);
    check("b2b_ld_addr", mem_addr, 32'h40);
    check("b2b_ld_ack_stall", 32'(stallM), 32'h0);
    tick();
    MemtoRegM = 1'b0; MemWriteM = 1'b1; ALUOutM = 32'h44; WriteDataM = 32'h5555_6666;
    #1 check("b2b_gap_req",   32'(mem_req), 32'h0);
    check("b2b_gap_stall", 32'(stallM), 32'h1);
    check("b2b_gap_rvalid", 32'(ReadValidM), 32'h1);
    tick();
    check("b2b_st_req",   32'(mem_req), 32'h1);
    check("b2b_st_we",    32'(mem_we), 32'h1);
    check("b2b_st_addr",  mem_addr, 32'h44);
    check("b2b_st_wdata", mem_wdata, 32'h5555_6666);
    check("b2b_st_stall", 32'(stallM), 32'h0);
    check("err_sticky",   32'(mem_err), 32'h1);
    tick();
    MemWriteM = 1'b0;
    #1 check("b2b_req_drop", 32'(mem_req), 32'h0);

    // Both flags set: treated as a store.
    tick();
    MemWriteM = 1'b1; MemtoRegM = 1'b1; ALUOutM = 32'h50; WriteDataM = 32'h7777_8888;
    #1 check("both_stall", 32'(stallM), 32'h1);
    tick();
    check("both_req", 32'(mem_req), 32'h1);
    check("both_we",  32'(mem_we), 32'h1);
    tick();
    MemWriteM = 1'b0; MemtoRegM = 1'b0;
    #1 check("both_no_rvalid", 32'(ReadValidM), 32'h0);
    check("both_req_drop", 32'(mem_req), 32'h0);

    // Reset asserted in the second ACCESS cycle of a load.
    mem_ready = 1'b0;
    tick();
    MemtoRegM = 1'b1; ALUOutM = 32'h60;
    tick(); tick();
    check("rstmid_req_pre", 32'(mem_req), 32'h1);
    reset_n = 1'b0;
    #1 check("rstmid_req",    32'(mem_req), 32'h0);
    check("rstmid_stall",  32'(stallM), 32'h0);
    check("rstmid_rvalid", 32'(ReadValidM), 32'h0);
    check("rstmid_err",    32'(mem_err), 32'h0);
    check("rstmid_addr",   mem_addr, 32'h0);
    MemtoRegM = 1'b0;
    tick();
    reset_n = 1'b1;
    #1 check("rel_req", 32'(mem_req), 32'h0);
    MemtoRegM = 1'b1; ALUOutM = 32'h70; mem_rdata = 32'hA5A5_5A5A;
    sb.push_back(32'hA5A5_5A5A);
    #1 check("rel_stall", 32'(stallM), 32'h1);
    tick();
    mem_ready = 1'b1;
    #1 check("rel_req_up", 32'(mem_req), 32'h1);
    check("rel_addr", mem_addr, 32'h70);
    tick();
    MemtoRegM = 1'b0; mem_ready = 1'b0;
    #1 check("rel_rvalid", 32'(ReadValidM), 32'h1);
    tick(); tick();
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_stage_ctrl
